// File: rtl/decoder_width_conv.sv
// ----------------------------------------------------------------------------
// decoder_width_conv
// Single-clock AXI-Stream width converter between the CDC FIFO and the decoder
// datapath. Up-sizes or down-sizes by any integer ratio, carries tkeep/tlast,
// and flushes a partial word immediately at packet end. The m_axis_* outputs
// come straight from one register stage.
//
// Ports
//   aclk, rst                  clock, asynchronous active-high reset
//   s_axis_tdata/tkeep/tlast   input beat (DWIDTH_IN bits, DWIDTH_IN/8 keep)
//   s_axis_tvalid/tready       input handshake (tready is combinational)
//   m_axis_tdata/tkeep/tlast   output beat (DWIDTH_OUT bits, DWIDTH_OUT/8 keep)
//   m_axis_tvalid/tready       output handshake (tvalid registered)
// ----------------------------------------------------------------------------
module decoder_width_conv #(
    parameter int unsigned DWIDTH_IN  = 64,
    parameter int unsigned DWIDTH_OUT = 256
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [DWIDTH_IN-1:0]    s_axis_tdata,
    input  logic [DWIDTH_IN/8-1:0]  s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DWIDTH_OUT-1:0]   m_axis_tdata,
    output logic [DWIDTH_OUT/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int unsigned KEEP_IN  = DWIDTH_IN / 8;
    localparam int unsigned KEEP_OUT = DWIDTH_OUT / 8;

    if (DWIDTH_OUT > DWIDTH_IN) begin : g_up
        // ------------------------------------------------------------------
        // Up-size: gather input beats into lanes of an accumulator, hand the
        // finished word to the output register on the last lane or tlast.
        // ------------------------------------------------------------------
        localparam int unsigned RATIO = DWIDTH_OUT / DWIDTH_IN;
        localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

        logic [CNT_W-1:0]      cnt_q,       cnt_d;
        logic [DWIDTH_OUT-1:0] acc_data_q,  acc_data_d;
        logic [KEEP_OUT-1:0]   acc_keep_q,  acc_keep_d;
        logic [DWIDTH_OUT-1:0] out_data_q,  out_data_d;
        logic [KEEP_OUT-1:0]   out_keep_q,  out_keep_d;
        logic                  out_last_q,  out_last_d;
        logic                  out_valid_q, out_valid_d;

        logic complete_c;
        logic s_ready_c;
        logic s_hs_c;
        logic m_hs_c;

        // Handshake qualifiers; only a completing beat can be stalled
        always_comb begin
            complete_c = (cnt_q == CNT_W'(RATIO - 1)) || s_axis_tlast;
            m_hs_c     = out_valid_q && m_axis_tready;
            s_ready_c  = !rst && (!complete_c || !out_valid_q || m_axis_tready);
            s_hs_c     = s_axis_tvalid && s_ready_c;
        end

        // Next-state: lane write, word hand-off, accumulator clear
        always_comb begin
            cnt_d       = cnt_q;
            acc_data_d  = acc_data_q;
            acc_keep_d  = acc_keep_q;
            out_data_d  = out_data_q;
            out_keep_d  = out_keep_q;
            out_last_d  = out_last_q;
            out_valid_d = out_valid_q;

            if (m_hs_c) begin
                out_valid_d = 1'b0;
            end

            if (s_hs_c) begin
                acc_data_d[cnt_q*DWIDTH_IN +: DWIDTH_IN] = s_axis_tdata;
                acc_keep_d[cnt_q*KEEP_IN +: KEEP_IN]     = s_axis_tkeep;
                if (complete_c) begin
                    // Unwritten lanes of a truncated word stay zero
                    out_data_d  = acc_data_d;
                    out_keep_d  = acc_keep_d;
                    out_last_d  = s_axis_tlast;
                    out_valid_d = 1'b1;
                    acc_data_d  = '0;
                    acc_keep_d  = '0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // State registers
        always_ff @(posedge aclk or posedge rst) begin
            if (rst) begin
                cnt_q       <= '0;
                acc_data_q  <= '0;
                acc_keep_q  <= '0;
                out_data_q  <= '0;
                out_keep_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                cnt_q       <= cnt_d;
                acc_data_q  <= acc_data_d;
                acc_keep_q  <= acc_keep_d;
                out_data_q  <= out_data_d;
                out_keep_q  <= out_keep_d;
                out_last_q  <= out_last_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign s_axis_tready = s_ready_c;
        assign m_axis_tdata  = out_data_q;
        assign m_axis_tkeep  = out_keep_q;
        assign m_axis_tlast  = out_last_q;
        assign m_axis_tvalid = out_valid_q;

    end else if (DWIDTH_IN > DWIDTH_OUT) begin : g_down
        // ------------------------------------------------------------------
        // Down-size: hold the input word and feed its lanes one at a time into
        // the output register; trailing empty lanes of a tlast word are dropped.
        // ------------------------------------------------------------------
        localparam int unsigned RATIO = DWIDTH_IN / DWIDTH_OUT;
        localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

        logic [DWIDTH_IN-1:0]  hold_data_q, hold_data_d;
        logic [KEEP_IN-1:0]    hold_keep_q, hold_keep_d;
        logic                  hold_last_q, hold_last_d;
        logic [CNT_W-1:0]      idx_q,       idx_d;
        logic [CNT_W-1:0]      last_lane_q, last_lane_d;
        logic [DWIDTH_OUT-1:0] out_data_q,  out_data_d;
        logic [KEEP_OUT-1:0]   out_keep_q,  out_keep_d;
        logic                  out_last_q,  out_last_d;
        logic                  out_valid_q, out_valid_d;

        logic [CNT_W-1:0] top_lane_c;
        logic [CNT_W-1:0] load_last_c;
        logic [CNT_W-1:0] next_idx_c;
        logic             is_last_c;
        logic             s_ready_c;
        logic             s_hs_c;
        logic             m_hs_c;

        // Highest lane of the incoming word with any keep bit set
        always_comb begin
            top_lane_c = '0;
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (|s_axis_tkeep[i*KEEP_OUT +: KEEP_OUT]) begin
                    top_lane_c = CNT_W'(i);
                end
            end
            load_last_c = s_axis_tlast ? top_lane_c : CNT_W'(RATIO - 1);
        end

        // Handshake qualifiers; a new word loads on the edge the last lane leaves
        always_comb begin
            next_idx_c = idx_q + CNT_W'(1);
            is_last_c  = (idx_q == last_lane_q);
            m_hs_c     = out_valid_q && m_axis_tready;
            s_ready_c  = !rst && (!out_valid_q || (m_axis_tready && is_last_c));
            s_hs_c     = s_axis_tvalid && s_ready_c;
        end

        // Next-state: lane advance and word load
        always_comb begin
            hold_data_d = hold_data_q;
            hold_keep_d = hold_keep_q;
            hold_last_d = hold_last_q;
            idx_d       = idx_q;
            last_lane_d = last_lane_q;
            out_data_d  = out_data_q;
            out_keep_d  = out_keep_q;
            out_last_d  = out_last_q;
            out_valid_d = out_valid_q;

            if (m_hs_c) begin
                if (is_last_c) begin
                    out_valid_d = 1'b0;
                end else begin
                    idx_d      = next_idx_c;
                    out_data_d = hold_data_q[next_idx_c*DWIDTH_OUT +: DWIDTH_OUT];
                    out_keep_d = hold_keep_q[next_idx_c*KEEP_OUT +: KEEP_OUT];
                    out_last_d = hold_last_q && (next_idx_c == last_lane_q);
                end
            end

            if (s_hs_c) begin
                hold_data_d = s_axis_tdata;
                hold_keep_d = s_axis_tkeep;
                hold_last_d = s_axis_tlast;
                idx_d       = '0;
                last_lane_d = load_last_c;
                out_data_d  = s_axis_tdata[DWIDTH_OUT-1:0];
                out_keep_d  = s_axis_tkeep[KEEP_OUT-1:0];
                out_last_d  = s_axis_tlast && (load_last_c == '0);
                out_valid_d = 1'b1;
            end
        end

        // State registers
        always_ff @(posedge aclk or posedge rst) begin
            if (rst) begin
                hold_data_q <= '0;
                hold_keep_q <= '0;
                hold_last_q <= 1'b0;
                idx_q       <= '0;
                last_lane_q <= '0;
                out_data_q  <= '0;
                out_keep_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                hold_data_q <= hold_data_d;
                hold_keep_q <= hold_keep_d;
                hold_last_q <= hold_last_d;
                idx_q       <= idx_d;
                last_lane_q <= last_lane_d;
                out_data_q  <= out_data_d;
                out_keep_q  <= out_keep_d;
                out_last_q  <= out_last_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign s_axis_tready = s_ready_c;
        assign m_axis_tdata  = out_data_q;
        assign m_axis_tkeep  = out_keep_q;
        assign m_axis_tlast  = out_last_q;
        assign m_axis_tvalid = out_valid_q;

    end else begin : g_same
        // ------------------------------------------------------------------
        // Equal widths: plain register slice.
        // ------------------------------------------------------------------
        logic [DWIDTH_OUT-1:0] out_data_q,  out_data_d;
        logic [KEEP_OUT-1:0]   out_keep_q,  out_keep_d;
        logic                  out_last_q,  out_last_d;
        logic                  out_valid_q, out_valid_d;
        logic                  s_ready_c;

        // Load when the slice is empty or draining this cycle
        always_comb begin
            s_ready_c   = !rst && (!out_valid_q || m_axis_tready);
            out_data_d  = out_data_q;
            out_keep_d  = out_keep_q;
            out_last_d  = out_last_q;
            out_valid_d = out_valid_q;
            if (out_valid_q && m_axis_tready) begin
                out_valid_d = 1'b0;
            end
            if (s_axis_tvalid && s_ready_c) begin
                out_data_d  = s_axis_tdata;
                out_keep_d  = s_axis_tkeep;
                out_last_d  = s_axis_tlast;
                out_valid_d = 1'b1;
            end
        end

        // State registers
        always_ff @(posedge aclk or posedge rst) begin
            if (rst) begin
                out_data_q  <= '0;
                out_keep_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                out_data_q  <= out_data_d;
                out_keep_q  <= out_keep_d;
                out_last_q  <= out_last_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign s_axis_tready = s_ready_c;
        assign m_axis_tdata  = out_data_q;
        assign m_axis_tkeep  = out_keep_q;
        assign m_axis_tlast  = out_last_q;
        assign m_axis_tvalid = out_valid_q;
    end

endmodule
